// File: rtl/stuff_bit_engine_pkg.sv
// Shared types and constants for the bit-stuffing engine.
package stuff_pkg;

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    STUFF = 2'd1,
    ERR   = 2'd2
  } stuff_state_t;

  localparam logic MODE_TX = 1'b0;
  localparam logic MODE_RX = 1'b1;

  localparam int RUN_LEN_MIN = 2;
  localparam int RUN_LEN_MAX = 15;

endpackage

// File: rtl/stuff_bit_engine_if.sv
// Bit-time strobe, data, mode and status bundle between link logic and the stuffing engine.
interface stuff_bit_engine_if #(
  parameter int RUN_LEN = 6,
  parameter int CNT_W   = 8
);
  localparam int RC_W = $clog2(RUN_LEN + 1);

  logic             shift_enable;
  logic             d_orig;
  logic             mode;
  logic             clear;
  logic             bit_stuff;
  logic             stuff_err;
  logic [CNT_W-1:0] stuff_count;
  logic [RC_W-1:0]  run_cnt;

  modport master (
    output shift_enable, d_orig, mode, clear,
    input  bit_stuff, stuff_err, stuff_count, run_cnt
  );

  modport slave (
    input  shift_enable, d_orig, mode, clear,
    output bit_stuff, stuff_err, stuff_count, run_cnt
  );
endinterface

// File: rtl/stuff_bit_engine_sat_counter.sv
// Saturating event counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/stuff_bit_engine.sv
// Bit-stuffing controller: counts runs of 1s, flags a stuff slot, inserts (TX) or checks (RX) it.
module stuff_bit_engine
  import stuff_pkg::*;
#(
  parameter int RUN_LEN = 6,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               n_rst,
  stuff_bit_engine_if.slave  bus
);

  localparam int              RC_W    = $clog2(RUN_LEN + 1);
  localparam logic [RC_W-1:0] RUN_MAX = RC_W'(RUN_LEN);

  if (RUN_LEN < RUN_LEN_MIN || RUN_LEN > RUN_LEN_MAX) begin : g_bad_run_len
    $error("stuff_bit_engine: RUN_LEN out of range");
  end

  stuff_state_t    state, state_nxt;
  logic [RC_W-1:0] run, run_nxt;
  logic            slot_done;

  always_comb begin
    state_nxt = state;
    run_nxt   = run;
    slot_done = 1'b0;
    if (bus.clear) begin
      state_nxt = COUNT;
      run_nxt   = '0;
    end else if (bus.shift_enable) begin
      case (state)
        COUNT: begin
          if (!bus.d_orig) begin
            run_nxt = '0;
          end else if (run == RUN_MAX - 1'b1) begin
            run_nxt   = RUN_MAX;
            state_nxt = STUFF;
          end else begin
            run_nxt = run + 1'b1;
          end
        end
        STUFF: begin
          // The slot bit itself never seeds the next run.
          if (bus.mode == MODE_TX || !bus.d_orig) begin
            run_nxt   = '0;
            state_nxt = COUNT;
            slot_done = 1'b1;
          end else begin
            state_nxt = ERR;
          end
        end
        ERR: begin
          state_nxt = ERR;
        end
        default: begin
          state_nxt = COUNT;
          run_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= COUNT;
      run   <= '0;
    end else begin
      state <= state_nxt;
      run   <= run_nxt;
    end
  end

  sat_counter #(.W(CNT_W)) u_stuff_cnt (
    .clk   (clk),
    .n_rst (n_rst),
    .clr   (bus.clear),
    .inc   (slot_done),
    .count (bus.stuff_count)
  );

  assign bus.bit_stuff = (state == STUFF);
  assign bus.stuff_err = (state == ERR);
  assign bus.run_cnt   = run;

endmodule

// File: tb/tb_stuff_bit_engine.sv
// Directed plus random bench for two stuff_bit_engine builds (6/8 and 3/2) against a run-length model.
module tb_stuff_bit_engine;
  import stuff_pkg::*;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  stuff_bit_engine_if #(.RUN_LEN(6), .CNT_W(8)) bus_a ();
  stuff_bit_engine_if #(.RUN_LEN(3), .CNT_W(2)) bus_b ();

  stuff_bit_engine #(.RUN_LEN(6), .CNT_W(8)) dut_a (.clk(clk), .n_rst(n_rst), .bus(bus_a));
  stuff_bit_engine #(.RUN_LEN(3), .CNT_W(2)) dut_b (.clk(clk), .n_rst(n_rst), .bus(bus_b));

  int checks = 0;
  int failures = 0;

  int m_run  [2];
  int m_cnt  [2];
  bit m_slot [2];
  bit m_err  [2];
  int rl     [2] = '{6, 3};
  int cmax   [2] = '{255, 3};
  int exp_seq [4] = '{1, 2, 3, 3};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_run[i] = 0; m_cnt[i] = 0; m_slot[i] = 0; m_err[i] = 0;
    end
  endtask

  // Run-length view: count ones, a full run opens a slot, the slot bit is consumed or faults.
  task automatic model_step(input bit se, input bit d, input bit m, input bit c);
    for (int i = 0; i < 2; i++) begin
      if (c) begin
        m_run[i] = 0; m_cnt[i] = 0; m_slot[i] = 0; m_err[i] = 0;
      end else if (se && !m_err[i]) begin
        if (m_slot[i]) begin
          m_slot[i] = 0;
          if (m == MODE_TX || !d) begin
            m_run[i] = 0;
            if (m_cnt[i] < cmax[i]) m_cnt[i]++;
          end else begin
            m_err[i] = 1;
          end
        end else if (d) begin
          m_run[i]++;
          if (m_run[i] == rl[i]) m_slot[i] = 1;
        end else begin
          m_run[i] = 0;
        end
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " a.bit_stuff"},   32'(bus_a.bit_stuff),   32'(m_slot[0]));
    chk({tag, " a.stuff_err"},   32'(bus_a.stuff_err),   32'(m_err[0]));
    chk({tag, " a.stuff_count"}, 32'(bus_a.stuff_count), m_cnt[0]);
    chk({tag, " a.run_cnt"},     32'(bus_a.run_cnt),     m_run[0]);
    chk({tag, " b.bit_stuff"},   32'(bus_b.bit_stuff),   32'(m_slot[1]));
    chk({tag, " b.stuff_err"},   32'(bus_b.stuff_err),   32'(m_err[1]));
    chk({tag, " b.stuff_count"}, 32'(bus_b.stuff_count), m_cnt[1]);
    chk({tag, " b.run_cnt"},     32'(bus_b.run_cnt),     m_run[1]);
  endtask

  // Called at a negedge: drive, let one rising edge sample, check at the following negedge.
  task automatic step(input string tag, input bit se, input bit d, input bit m, input bit c);
    bus_a.shift_enable = se; bus_a.d_orig = d; bus_a.mode = m; bus_a.clear = c;
    bus_b.shift_enable = se; bus_b.d_orig = d; bus_b.mode = m; bus_b.clear = c;
    @(posedge clk);
    model_step(se, d, m, c);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic ones(input string tag, input int n, input bit m);
    for (int k = 0; k < n; k++) step(tag, 1'b1, 1'b1, m, 1'b0);
  endtask

  initial begin
    bus_a.shift_enable = 0; bus_a.d_orig = 0; bus_a.mode = 0; bus_a.clear = 0;
    bus_b.shift_enable = 0; bus_b.d_orig = 0; bus_b.mode = 0; bus_b.clear = 0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset a.bit_stuff", 32'(bus_a.bit_stuff), 0);
    chk("reset a.stuff_err", 32'(bus_a.stuff_err), 0);
    chk("reset a.stuff_count", 32'(bus_a.stuff_count), 0);
    chk("reset a.run_cnt", 32'(bus_a.run_cnt), 0);
    n_rst = 1'b1;
    @(negedge clk);
    check_all("post_reset");

    // TX: six ones open a slot that survives idle cycles, the next shift closes it.
    ones("tx_run", 6, MODE_TX);
    chk("tx_run slot_open", 32'(bus_a.bit_stuff), 1);
    for (int k = 0; k < 3; k++) step("tx_idle", 1'b0, 1'b1, MODE_TX, 1'b0);
    chk("tx_idle slot_held", 32'(bus_a.bit_stuff), 1);
    step("tx_slot", 1'b1, 1'b1, MODE_TX, 1'b0);
    chk("tx_slot bit_stuff", 32'(bus_a.bit_stuff), 0);
    chk("tx_slot count", 32'(bus_a.stuff_count), 1);
    chk("tx_slot run", 32'(bus_a.run_cnt), 0);

    // TX: a zero breaks the run, so five ones on either side never stuff.
    step("clr1", 1'b0, 1'b0, MODE_TX, 1'b1);
    ones("tx_5a", 5, MODE_TX);
    step("tx_zero", 1'b1, 1'b0, MODE_TX, 1'b0);
    ones("tx_5b", 5, MODE_TX);
    chk("tx_5b no_stuff", 32'(bus_a.bit_stuff), 0);
    chk("tx_5b run", 32'(bus_a.run_cnt), 5);

    // RX: good slot, then a violating slot, frozen error, then clear.
    step("clr2", 1'b0, 1'b0, MODE_RX, 1'b1);
    ones("rx_run1", 6, MODE_RX);
    step("rx_good", 1'b1, 1'b0, MODE_RX, 1'b0);
    chk("rx_good count", 32'(bus_a.stuff_count), 1);
    chk("rx_good err", 32'(bus_a.stuff_err), 0);
    ones("rx_run2", 6, MODE_RX);
    step("rx_bad", 1'b1, 1'b1, MODE_RX, 1'b0);
    chk("rx_bad err", 32'(bus_a.stuff_err), 1);
    ones("rx_frozen", 3, MODE_RX);
    chk("rx_frozen run", 32'(bus_a.run_cnt), 6);
    chk("rx_frozen bit_stuff", 32'(bus_a.bit_stuff), 0);
    chk("rx_frozen err", 32'(bus_a.stuff_err), 1);
    step("rx_clear", 1'b0, 1'b0, MODE_RX, 1'b1);
    chk("rx_clear err", 32'(bus_a.stuff_err), 0);
    chk("rx_clear count", 32'(bus_a.stuff_count), 0);

    // Clear beats a simultaneous shift that would have completed the run.
    ones("pri_run", 5, MODE_TX);
    step("pri_clear", 1'b1, 1'b1, MODE_TX, 1'b1);
    chk("pri_clear run", 32'(bus_a.run_cnt), 0);
    step("pri_idle", 1'b0, 1'b0, MODE_TX, 1'b0);
    chk("pri_idle bit_stuff", 32'(bus_a.bit_stuff), 0);

    // Asynchronous reset in STUFF, observed before any rising edge.
    ones("rst_run", 6, MODE_TX);
    #2 n_rst = 1'b0;
    #1;
    chk("async_rst bit_stuff", 32'(bus_a.bit_stuff), 0);
    chk("async_rst run", 32'(bus_a.run_cnt), 0);
    model_reset();
    @(negedge clk);
    n_rst = 1'b1;
    step("post_async", 1'b0, 1'b0, MODE_TX, 1'b0);

    // Short run, narrow counter: two slots give 2, then saturation at 3.
    step("clr3", 1'b0, 1'b0, MODE_TX, 1'b1);
    for (int e = 0; e < 4; e++) begin
      step("sat_zero", 1'b1, 1'b0, MODE_TX, 1'b0);
      ones("sat_run", 3, MODE_TX);
      chk("sat_run b.slot", 32'(bus_b.bit_stuff), 1);
      step("sat_slot", 1'b1, 1'b0, MODE_TX, 1'b0);
      chk("sat_slot b.count", 32'(bus_b.stuff_count), exp_seq[e]);
    end

    // Random traffic, ones-heavy so both builds keep reaching slots and faults.
    for (int k = 0; k < 600; k++) begin
      step("rand",
           bit'($urandom_range(3, 0) != 0),
           bit'($urandom_range(7, 0) != 0),
           bit'($urandom_range(1, 0)),
           bit'($urandom_range(39, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
